perceptron_trainer: RTL

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

---
 rtl/nn_pkg.sv | 20 ++
 rtl/perceptron_trainer_if.sv | 29 ++
 rtl/sm_step_unit.sv | 41 ++++
 rtl/perceptron_trainer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the perceptron trainer: FSM states,
// the default fixed-point width, the learning rate and the magnitude ceiling.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EVAL,
    UPDATE,
    CHECK,
    DONE
  } state_e;

  // Sign-magnitude word: 1 sign bit, 15 integer bits, 16 fraction bits.
  localparam int              NN_W       = 32;
  localparam logic [NN_W-1:0] NN_LR      = 32'h0000_4000;
  localparam logic [NN_W-2:0] NN_MAG_MAX = '1;

endpackage

// File: rtl/perceptron_trainer_if.sv
// Bus between the trainer, its sample memory and the external neuron:
// registered-read memory port plus the operands/weights fed to the neuron.
interface perceptron_trainer_if #(
  parameter int W  = nn_pkg::NN_W,
  parameter int AW = 2
);

  logic [AW-1:0] sample_addr_out;
  logic          sample_x1_in;
  logic          sample_x2_in;
  logic          sample_target_in;
  logic [W-1:0]  x1_out;
  logic [W-1:0]  x2_out;
  logic [W-1:0]  w1_out;
  logic [W-1:0]  w2_out;
  logic [W-1:0]  wb_out;
  logic          neuron_out_in;

  modport master (
    output sample_addr_out, x1_out, x2_out, w1_out, w2_out, wb_out,
    input  sample_x1_in, sample_x2_in, sample_target_in, neuron_out_in
  );

  modport slave (
    input  sample_addr_out, x1_out, x2_out, w1_out, w2_out, wb_out,
    output sample_x1_in, sample_x2_in, sample_target_in, neuron_out_in
  );

endinterface

// File: rtl/sm_step_unit.sv
// Saturating sign-magnitude step: w_o = w_i +/- LR when enabled, else w_i.
// Magnitude clamps at all-ones and a zero result always carries sign 0.
module sm_step_unit
  import nn_pkg::*;
#(
  parameter int           W       = NN_W,
  parameter logic [W-2:0] MAG_MAX = NN_MAG_MAX
) (
  input  logic [W-1:0] w_i,
  input  logic [W-2:0] lr_mag_i,
  input  logic         en_i,
  input  logic         neg_i,
  output logic [W-1:0] w_o
);

  logic         w_s;
  logic [W-2:0] w_m;
  logic [W-1:0] sum;
  logic         r_s;
  logic [W-2:0] r_m;

  assign w_s = w_i[W-1];
  assign w_m = w_i[W-2:0];
  assign sum = {1'b0, w_m} + {1'b0, lr_mag_i};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    r_s = w_s;
    r_m = w_m;
    if (w_s == neg_i) begin
      r_m = sum[W-1] ? MAG_MAX : sum[W-2:0];
    end else if (w_m >= lr_mag_i) begin
      r_m = w_m - lr_mag_i;
    end else begin
      r_s = neg_i;
      r_m = lr_mag_i - w_m;
    end
    w_o = en_i ? {r_s & (|r_m), r_m} : w_i;
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training sequencer: walks the sample memory epoch by epoch,
// evaluates the external neuron and applies the perceptron rule until converged.
module perceptron_trainer
  import nn_pkg::*;
#(
  parameter int SIGN       = 1,
  parameter int Q_M        = 15,
  parameter int Q_N        = 16,
  parameter int N_SAMPLES  = 4,
  parameter int MAX_EPOCHS = 64,
  parameter logic [SIGN+Q_M+Q_N-1:0] LR      = NN_LR,
  parameter logic [SIGN+Q_M+Q_N-1:0] W1_INIT = '0,
  parameter logic [SIGN+Q_M+Q_N-1:0] W2_INIT = '0,
  parameter logic [SIGN+Q_M+Q_N-1:0] WB_INIT = '0,
  localparam int W  = SIGN + Q_M + Q_N,
  localparam int AW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  localparam int EW = $clog2(MAX_EPOCHS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  perceptron_trainer_if.master bus,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 converged_out,
  output logic [EW-1:0]        epoch_count_out,
  output logic [EW-1:0]        error_count_out
);

  localparam logic [W-2:0] LR_MAG = LR[W-2:0];

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          x1_q, x1_d, x2_q, x2_d, tgt_q, tgt_d;
  logic          err_nz_q, err_nz_d, err_neg_q, err_neg_d;
  logic          conv_q, conv_d;
  logic [EW-1:0] epoch_q, epoch_d, errc_q, errc_d;
  logic [W-1:0]  w1_q, w1_d, w2_q, w2_d, wb_q, wb_d;
  logic [W-1:0]  w1_step, w2_step, wb_step;

  sm_step_unit #(.W(W)) u_step_w1 (
    .w_i(w1_q), .lr_mag_i(LR_MAG), .en_i(x1_q), .neg_i(err_neg_q), .w_o(w1_step)
  );
  sm_step_unit #(.W(W)) u_step_w2 (
    .w_i(w2_q), .lr_mag_i(LR_MAG), .en_i(x2_q), .neg_i(err_neg_q), .w_o(w2_step)
  );
  sm_step_unit #(.W(W)) u_step_wb (
    .w_i(wb_q), .lr_mag_i(LR_MAG), .en_i(1'b1), .neg_i(err_neg_q), .w_o(wb_step)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    tgt_d     = tgt_q;
    err_nz_d  = err_nz_q;
    err_neg_d = err_neg_q;
    conv_d    = conv_q;
    epoch_d   = epoch_q;
    errc_d    = errc_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    wb_d      = wb_q;
    case (state_q)
      IDLE: if (start_in) begin
        epoch_d = '0;
        errc_d  = '0;
        conv_d  = 1'b0;
        idx_d   = '0;
        state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        x1_d    = bus.sample_x1_in;
        x2_d    = bus.sample_x2_in;
        tgt_d   = bus.sample_target_in;
        state_d = EVAL;
      end
      // err = target - out: nonzero when they differ, negative when out=1, target=0.
      EVAL: begin
        err_nz_d  = tgt_q ^ bus.neuron_out_in;
        err_neg_d = bus.neuron_out_in & ~tgt_q;
        state_d   = UPDATE;
      end
      UPDATE: begin
        if (err_nz_q) begin
          w1_d   = w1_step;
          w2_d   = w2_step;
          wb_d   = wb_step;
          errc_d = errc_q + EW'(1);
        end
        if (idx_q == AW'(N_SAMPLES - 1)) begin
          state_d = CHECK;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = FETCH;
        end
      end
      CHECK: begin
        epoch_d = epoch_q + EW'(1);
        if (errc_q == '0) begin
          conv_d  = 1'b1;
          state_d = DONE;
        end else if (epoch_d == EW'(MAX_EPOCHS)) begin
          state_d = DONE;
        end else begin
          errc_d  = '0;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      x1_q      <= 1'b0;
      x2_q      <= 1'b0;
      tgt_q     <= 1'b0;
      err_nz_q  <= 1'b0;
      err_neg_q <= 1'b0;
      conv_q    <= 1'b0;
      epoch_q   <= '0;
      errc_q    <= '0;
      w1_q      <= W1_INIT;
      w2_q      <= W2_INIT;
      wb_q      <= WB_INIT;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      tgt_q     <= tgt_d;
      err_nz_q  <= err_nz_d;
      err_neg_q <= err_neg_d;
      conv_q    <= conv_d;
      epoch_q   <= epoch_d;
      errc_q    <= errc_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      wb_q      <= wb_d;
    end
  end

  assign bus.sample_addr_out = idx_q;
  assign bus.x1_out          = {{(W-1){1'b0}}, x1_q};
  assign bus.x2_out          = {{(W-1){1'b0}}, x2_q};
  assign bus.w1_out          = w1_q;
  assign bus.w2_out          = w2_q;
  assign bus.wb_out          = wb_q;
  assign busy_out            = (state_q != IDLE) && (state_q != DONE);
  assign done_out            = (state_q == DONE);
  assign converged_out       = conv_q;
  assign epoch_count_out     = epoch_q;
  assign error_count_out     = errc_q;

endmodule
